// File: rtl/btn_pulse_gen_if.sv
// Button pin and debounced strobe bundle between the board-side logic and btn_pulse_gen.
// The master drives the raw pin; the slave (btn_pulse_gen) returns the level and strobes.
interface btn_pulse_gen_if;
   logic btn_in;
   logic btn_level;
   logic enable;
   logic release_pulse;

   modport master (
      output btn_in,
      input  btn_level,
      input  enable,
      input  release_pulse
   );

   modport slave (
      input  btn_in,
      output btn_level,
      output enable,
      output release_pulse
   );
endinterface

// File: rtl/btn_pulse_gen.sv
// Push-button synchronizer + debounce FSM producing a one-cycle press strobe and release strobe.
// Optional auto-repeat of the press strobe while held: define BTN_AUTOREPEAT_EN.
module btn_pulse_gen #(
   parameter int DEB_CYCLES     = 4,
   parameter int CNT_W          = 16,
   parameter int BTN_ACTIVE_LOW = 0,
   parameter int REPEAT_DELAY   = 20,
   parameter int REPEAT_PERIOD  = 5,
   parameter int RPT_W          = 16
) (
   input logic         clk,
   input logic         reset_n,
   btn_pulse_gen_if.slave bus
);

   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      HELD         = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             btn_raw;
   logic             sync_p0, sync_p1;
   logic             btn_s;
   logic             level_q, level_nxt;
   logic             enable_q, enable_nxt;
   logic             release_q, release_nxt;

   // Polarity is normalised before the first flop so reset value 0 always means "not pressed".
   assign btn_raw = bus.btn_in ^ (BTN_ACTIVE_LOW != 0);

   // ---- stage p0/p1: two-flop synchronizer ----
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
      end else begin
         sync_p0 <= btn_raw;
         sync_p1 <= sync_p0;
      end
   end

   assign btn_s = sync_p1;

`ifdef BTN_AUTOREPEAT_EN
   logic [RPT_W-1:0] rcnt, rcnt_nxt;
   logic             rpt_arm, rpt_arm_nxt;
   logic [RPT_W-1:0] rpt_last;

   // First repeat waits the long delay, later ones use the period.
   assign rpt_last = rpt_arm ? RPT_W'(REPEAT_PERIOD - 1) : RPT_W'(REPEAT_DELAY - 1);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rcnt    <= '0;
         rpt_arm <= 1'b0;
      end else begin
         rcnt    <= rcnt_nxt;
         rpt_arm <= rpt_arm_nxt;
      end
   end
`endif

   // ---- stage p2: FSM state and registered outputs ----
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         cnt       <= '0;
         level_q   <= 1'b0;
         enable_q  <= 1'b0;
         release_q <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         level_q   <= level_nxt;
         enable_q  <= enable_nxt;
         release_q <= release_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (btn_s) begin
               state_nxt = PRESS_WAIT;
               cnt_nxt   = CNT_W'(1);
            end
         end
         PRESS_WAIT: begin
            if (!btn_s)
               state_nxt = IDLE;
            else if (cnt == DEB_LAST)
               state_nxt = HELD;
            else
               cnt_nxt = cnt + CNT_W'(1);
         end
         HELD: begin
            if (!btn_s) begin
               state_nxt = RELEASE_WAIT;
               cnt_nxt   = CNT_W'(1);
            end
         end
         RELEASE_WAIT: begin
            if (btn_s)
               state_nxt = HELD;
            else if (cnt == DEB_LAST)
               state_nxt = IDLE;
            else
               cnt_nxt = cnt + CNT_W'(1);
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      level_nxt   = level_q;
      enable_nxt  = 1'b0;
      release_nxt = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      rcnt_nxt    = rcnt;
      rpt_arm_nxt = rpt_arm;
`endif
      if (state == PRESS_WAIT && state_nxt == HELD) begin
         level_nxt  = 1'b1;
         enable_nxt = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
         rcnt_nxt    = '0;
         rpt_arm_nxt = 1'b0;
`endif
      end
      if (state == RELEASE_WAIT && state_nxt == IDLE) begin
         level_nxt   = 1'b0;
         release_nxt = 1'b1;
      end
`ifdef BTN_AUTOREPEAT_EN
      // A bounce back into HELD restarts the timer at the short period; RELEASE_WAIT just freezes it.
      if (state == RELEASE_WAIT && state_nxt == HELD) begin
         rcnt_nxt    = '0;
         rpt_arm_nxt = 1'b1;
      end else if (state == HELD && state_nxt == HELD) begin
         if (rcnt == rpt_last) begin
            enable_nxt  = 1'b1;
            rcnt_nxt    = '0;
            rpt_arm_nxt = 1'b1;
         end else begin
            rcnt_nxt = rcnt + RPT_W'(1);
         end
      end
`endif
   end

   assign bus.btn_level     = level_q;
   assign bus.enable        = enable_q;
   assign bus.release_pulse = release_q;

endmodule

// File: tb/tb_btn_pulse_gen.sv
// Scoreboard bench for btn_pulse_gen: expected strobe cycles are queued when the pin is driven.
// Honours BTN_AUTOREPEAT_EN when the same define is given to the bench.
module tb_btn_pulse_gen;

   localparam int DEB        = 4;
   localparam int LAT        = DEB + 2;
   localparam int RPT_DELAY  = 20;
   localparam int RPT_PERIOD = 5;

   typedef struct {
      bit is_rel;
      int cyc;
   } exp_t;

   logic clk;
   logic reset_n;
   int   cyc;
   int   n_checks;
   int   n_errors;
   int   exp_en;
   logic [3:0] cnt4;
   exp_t sb[$];

   btn_pulse_gen_if bus_if ();

   btn_pulse_gen dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      cyc  = 0;
      cnt4 = '0;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Model of the downstream 4-bit counter fed by the strobe.
   always @(posedge clk) if (bus_if.enable === 1'b1) cnt4 <= cnt4 + 4'd1;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic push_ev(input bit is_rel, input int c);
      exp_t e;
      e.is_rel = is_rel;
      e.cyc    = c;
      sb.push_back(e);
      if (!is_rel) exp_en++;
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

`ifdef BTN_AUTOREPEAT_EN
   task automatic push_repeats(input int first, input int last);
      for (int t = first; t <= last; t += RPT_PERIOD) push_ev(1'b0, t);
   endtask
`endif

   // Every strobe must match the oldest expected event in kind and cycle.
   always @(negedge clk) begin
      if (reset_n === 1'b1 && (bus_if.enable === 1'b1 || bus_if.release_pulse === 1'b1)) begin
         check_val("strobe_exclusive", {31'd0, bus_if.enable & bus_if.release_pulse}, 32'd0);
         check_val("strobe_expected", {31'd0, sb.size() != 0}, 32'd1);
         if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check_val("strobe_kind", {31'd0, bus_if.release_pulse}, {31'd0, e.is_rel});
            check_val("strobe_cycle", cyc, e.cyc);
            check_val("level_at_strobe", {31'd0, bus_if.btn_level}, {31'd0, !e.is_rel});
         end
      end
   end

   initial begin
      int n;
      int hold;
      int m;
      int k;
      n_checks = 0;
      n_errors = 0;
      exp_en   = 0;
      reset_n  = 1'b0;
      bus_if.btn_in = 1'b0;

      tick(3);
      check_val("rst_level", {31'd0, bus_if.btn_level}, 32'd0);
      check_val("rst_enable", {31'd0, bus_if.enable}, 32'd0);
      check_val("rst_release", {31'd0, bus_if.release_pulse}, 32'd0);
      reset_n = 1'b1;
      tick(2);

      // Clean press, long hold, clean release.
      n = cyc;
      bus_if.btn_in = 1'b1;
      push_ev(1'b0, n + LAT);
`ifdef BTN_AUTOREPEAT_EN
      hold = 40;
      push_repeats(n + LAT + RPT_DELAY, n + hold + 2);
`else
      hold = 20;
`endif
      tick(8);
      check_val("cnt_after_press", cnt4, 32'd1);
      check_val("level_held", {31'd0, bus_if.btn_level}, 32'd1);
      tick(hold - 8);
      bus_if.btn_in = 1'b0;
      push_ev(1'b1, cyc + LAT);
      tick(10);
      check_val("level_released", {31'd0, bus_if.btn_level}, 32'd0);
      check_val("cnt_after_release", cnt4, exp_en % 16);

      // Three-sample glitch must be rejected.
      bus_if.btn_in = 1'b1;
      tick(3);
      bus_if.btn_in = 1'b0;
      tick(8);
      check_val("glitch_level", {31'd0, bus_if.btn_level}, 32'd0);
      check_val("glitch_cnt", cnt4, exp_en % 16);

      // Four samples is the shortest accepted press; release follows immediately.
      n = cyc;
      bus_if.btn_in = 1'b1;
      push_ev(1'b0, n + LAT);
      tick(4);
      bus_if.btn_in = 1'b0;
      push_ev(1'b1, cyc + LAT);
      tick(10);
      check_val("min_press_level", {31'd0, bus_if.btn_level}, 32'd0);

      // Two-cycle low bounce while held: no release, level stays high.
      n = cyc;
      bus_if.btn_in = 1'b1;
      push_ev(1'b0, n + LAT);
      tick(11);
      m = cyc;
      bus_if.btn_in = 1'b0;
      tick(2);
      bus_if.btn_in = 1'b1;
      tick(2);
      check_val("bounce_level_rw", {31'd0, bus_if.btn_level}, 32'd1);
      tick(4);
      check_val("bounce_level_held", {31'd0, bus_if.btn_level}, 32'd1);
`ifdef BTN_AUTOREPEAT_EN
      // Back in HELD at m+5, so the restarted timer fires one period later.
      push_ev(1'b0, m + 5 + RPT_PERIOD);
`endif
      bus_if.btn_in = 1'b0;
      push_ev(1'b1, cyc + LAT);
      tick(10);
      check_val("bounce_released", {31'd0, bus_if.btn_level}, 32'd0);

      // Reset while held clears outputs at once; a still-held button re-arms from scratch.
      n = cyc;
      bus_if.btn_in = 1'b1;
      push_ev(1'b0, n + LAT);
      tick(10);
      check_val("pre_reset_level", {31'd0, bus_if.btn_level}, 32'd1);
      reset_n = 1'b0;
      #1;
      check_val("async_rst_level", {31'd0, bus_if.btn_level}, 32'd0);
      check_val("async_rst_enable", {31'd0, bus_if.enable}, 32'd0);
      check_val("async_rst_release", {31'd0, bus_if.release_pulse}, 32'd0);
      tick(3);
      check_val("in_rst_level", {31'd0, bus_if.btn_level}, 32'd0);
      k = cyc;
      reset_n = 1'b1;
      push_ev(1'b0, k + LAT);
      tick(10);
      check_val("post_rst_level", {31'd0, bus_if.btn_level}, 32'd1);
      bus_if.btn_in = 1'b0;
      push_ev(1'b1, cyc + LAT);
      tick(10);
      check_val("post_rst_released", {31'd0, bus_if.btn_level}, 32'd0);

      tick(4);
      check_val("sb_drained", sb.size(), 32'd0);
      check_val("final_cnt", cnt4, exp_en % 16);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
